// File: rtl/vx_warp_ibuffer_pkg.sv
// Shared types and sizes for the per-warp instruction buffer.
// The ibuffer payload layout is defined here so decode and issue agree on field positions.
package vx_warp_ibuffer_pkg;

    localparam int IBUF_NUM_WARPS = 4;
    localparam int IBUF_DEPTH     = 4;
    localparam bit EXT_V_ENABLE   = 1'b1;
    localparam int NW_WIDTH       = (IBUF_NUM_WARPS > 1) ? $clog2(IBUF_NUM_WARPS) : 1;

    // Vector fields stay in the layout even when EXT_V_ENABLE is off; decode ties them to zero.
    typedef struct packed {
        logic [31:0] pc;
        logic        wb;
        logic [4:0]  rd;
        logic [3:0]  op_type;
        logic [2:0]  op_mod;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        is_vec;
        logic [4:0]  vd;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
    } ibuf_data_t;

    localparam int IBUF_DATAW = $bits(ibuf_data_t);

    typedef logic [$clog2(IBUF_DEPTH + 1)-1:0] ibuf_count_t;

endpackage

// File: rtl/vx_ibuffer_queue.sv
// Single-warp circular FIFO with synchronous flush and occupancy output.
// Head data is read asynchronously from the storage array so it is visible the cycle after enqueue.
module vx_ibuffer_queue #(
    parameter int  DEPTH = 4,
    parameter int  DATAW = 8,
    localparam int ADDRW = $clog2(DEPTH),
    localparam int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             enq_valid,
    input  logic [DATAW-1:0] enq_data,
    output logic             full,
    output logic             deq_valid,
    output logic [DATAW-1:0] deq_data,
    input  logic             deq_ready,
    output logic [CNTW-1:0]  count
);

    logic [DATAW-1:0] mem [DEPTH];
    logic [ADDRW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CNTW-1:0]  count_reg, count_next;
    logic             push, pop;

    // A full queue refuses enqueue even when its head leaves in the same cycle.
    assign full      = (count_reg == CNTW'(DEPTH));
    assign deq_valid = (count_reg != '0) && !flush;
    assign push      = enq_valid && !full && !flush;
    assign pop       = deq_valid && deq_ready;
    assign deq_data  = mem[rd_ptr_reg];
    assign count     = count_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNTW'(1);
            2'b01:   count_next = count_reg - CNTW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + ADDRW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + ADDRW'(1);
            count_reg <= count_next;
        end
    end

`ifndef SYNTHESIS
    a_no_deq_empty: assert property (@(posedge clk) disable iff (reset) !(pop && (count_reg == '0)));
    a_count_bound:  assert property (@(posedge clk) disable iff (reset) count_reg <= CNTW'(DEPTH));
`endif

endmodule

// File: rtl/vx_warp_ibuffer.sv
// Per-warp instruction buffer: one enqueue per cycle steered by warp id, independent per-warp heads.
// Each warp owns a vx_ibuffer_queue; this level decodes the target warp and packs the per-warp outputs.
module vx_warp_ibuffer
    import vx_warp_ibuffer_pkg::*;
#(
    parameter int  NUM_WARPS = IBUF_NUM_WARPS,
    parameter int  DEPTH     = IBUF_DEPTH,
    parameter int  DATAW     = IBUF_DATAW,
    parameter int  ALMFULL   = DEPTH - 1,
    localparam int WIDW      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int CNTW      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enq_valid,
    input  logic [WIDW-1:0]           enq_wid,
    input  logic [DATAW-1:0]          enq_data,
    output logic                      enq_ready,
    output logic [NUM_WARPS-1:0]      deq_valid,
    output logic [NUM_WARPS*DATAW-1:0] deq_data,
    input  logic [NUM_WARPS-1:0]      deq_ready,
    input  logic [NUM_WARPS-1:0]      flush_mask,
    output logic [NUM_WARPS-1:0]      almost_full,
    output logic [NUM_WARPS*CNTW-1:0] count,
    output logic                      busy
);

    logic [NUM_WARPS-1:0] full_vec;
    logic [NUM_WARPS-1:0] nonempty;

    for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
        logic [CNTW-1:0] warp_count;
        logic            warp_enq;

        assign warp_enq = enq_valid && (int'(enq_wid) == gi);

        vx_ibuffer_queue #(
            .DEPTH (DEPTH),
            .DATAW (DATAW)
        ) u_queue (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush_mask[gi]),
            .enq_valid (warp_enq),
            .enq_data  (enq_data),
            .full      (full_vec[gi]),
            .deq_valid (deq_valid[gi]),
            .deq_data  (deq_data[gi*DATAW +: DATAW]),
            .deq_ready (deq_ready[gi]),
            .count     (warp_count)
        );

        assign count[gi*CNTW +: CNTW] = warp_count;
        assign almost_full[gi]        = int'(warp_count) >= ALMFULL;
        assign nonempty[gi]           = (warp_count != '0);
    end

    // An out-of-range warp id is never ready, so a bad tag cannot be silently accepted.
    assign enq_ready = (int'(enq_wid) < NUM_WARPS) && !full_vec[enq_wid] && !flush_mask[enq_wid];
    assign busy      = |nonempty;

`ifndef SYNTHESIS
    a_wid_range: assert property (@(posedge clk) disable iff (reset) enq_valid |-> (int'(enq_wid) < NUM_WARPS));
`endif

endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// Bench for vx_warp_ibuffer: directed vector table with constant expectations, then random traffic,
// every cycle compared against per-warp queue model.
module tb_vx_warp_ibuffer;
    import vx_warp_ibuffer_pkg::*;

    localparam int NW      = 4;
    localparam int DEPTH   = 4;
    localparam int DW      = IBUF_DATAW;
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int ALMFULL = DEPTH - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enq_valid = 1'b0;
    logic [1:0]       enq_wid = '0;
    logic [DW-1:0]    enq_data = '0;
    logic             enq_ready;
    logic [NW-1:0]    deq_valid;
    logic [NW*DW-1:0] deq_data;
    logic [NW-1:0]    deq_ready = '0;
    logic [NW-1:0]    flush_mask = '0;
    logic [NW-1:0]    almost_full;
    logic [NW*CW-1:0] count;
    logic             busy;

    always #5 clk = ~clk;

    vx_warp_ibuffer #(
        .NUM_WARPS (NW),
        .DEPTH     (DEPTH),
        .DATAW     (DW),
        .ALMFULL   (ALMFULL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enq_valid   (enq_valid),
        .enq_wid     (enq_wid),
        .enq_data    (enq_data),
        .enq_ready   (enq_ready),
        .deq_valid   (deq_valid),
        .deq_data    (deq_data),
        .deq_ready   (deq_ready),
        .flush_mask  (flush_mask),
        .almost_full (almost_full),
        .count       (count),
        .busy        (busy)
    );

    typedef struct {
        logic          rst;
        logic          ev;
        logic [1:0]    wid;
        logic [DW-1:0] data;
        logic [NW-1:0] dr;
        logic [NW-1:0] fm;
        bit            chk;
        logic          x_rdy;
        logic [NW-1:0] x_dv;
        logic [NW*CW-1:0] x_cnt;
        logic [NW-1:0] x_af;
        logic          x_busy;
        int            hw;
        logic [DW-1:0] x_head;
    } vec_t;

    logic [DW-1:0] mq [NW][$];
    int nvec = 0;
    int nbad = 0;
    int cyc  = 0;

    function automatic logic [DW-1:0] pl(input int i);
        logic [95:0] t;
        t = {32'hC0DE_0000 | 32'(i), 32'h5A5A_0000 | 32'(i), 32'(i)};
        return DW'(t);
    endfunction

    function automatic logic [DW-1:0] rnd();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return DW'(t);
    endfunction

    function automatic vec_t mk(input logic rst, input logic ev, input logic [1:0] wid,
                                input logic [DW-1:0] data, input logic [NW-1:0] dr, input logic [NW-1:0] fm);
        vec_t v;
        v.rst = rst; v.ev = ev; v.wid = wid; v.data = data; v.dr = dr; v.fm = fm;
        v.chk = 1'b0; v.x_rdy = 1'b0; v.x_dv = '0; v.x_cnt = '0; v.x_af = '0;
        v.x_busy = 1'b0; v.hw = -1; v.x_head = '0;
        return v;
    endfunction

    function automatic vec_t tv(input logic ev, input logic [1:0] wid, input logic [DW-1:0] data,
                                input logic [NW-1:0] dr, input logic [NW-1:0] fm,
                                input logic x_rdy, input logic [NW-1:0] x_dv, input logic [NW*CW-1:0] x_cnt,
                                input logic [NW-1:0] x_af, input logic x_busy, input int hw,
                                input logic [DW-1:0] x_head);
        vec_t v;
        v = mk(1'b0, ev, wid, data, dr, fm);
        v.chk = 1'b1; v.x_rdy = x_rdy; v.x_dv = x_dv; v.x_cnt = x_cnt; v.x_af = x_af;
        v.x_busy = x_busy; v.hw = hw; v.x_head = x_head;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s cyc %0d: got %h required %h", nm, cyc, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        logic             m_rdy;
        logic             m_busy;
        logic [NW-1:0]    m_dv;
        logic [NW-1:0]    m_af;
        logic [NW*CW-1:0] m_cnt;
        @(negedge clk);
        reset = v.rst; enq_valid = v.ev; enq_wid = v.wid; enq_data = v.data;
        deq_ready = v.dr; flush_mask = v.fm;
        #1;
        m_rdy  = (mq[v.wid].size() < DEPTH) && !v.fm[v.wid];
        m_busy = 1'b0;
        m_dv   = '0;
        m_af   = '0;
        m_cnt  = '0;
        for (int w = 0; w < NW; w++) begin
            m_dv[w]           = (mq[w].size() != 0) && !v.fm[w];
            m_cnt[w*CW +: CW] = CW'(mq[w].size());
            m_af[w]           = mq[w].size() >= ALMFULL;
            m_busy            = m_busy | (mq[w].size() != 0);
        end
        cyc++;
        $display("cyc %0d rst=%b enq=%b wid=%0d dr=%b fm=%b | rdy=%b dv=%b cnt=%h af=%b busy=%b",
                 cyc, v.rst, v.ev, v.wid, v.dr, v.fm, enq_ready, deq_valid, count, almost_full, busy);
        chk("model enq_ready", DW'(enq_ready), DW'(m_rdy));
        chk("model deq_valid", DW'(deq_valid), DW'(m_dv));
        chk("model count", DW'(count), DW'(m_cnt));
        chk("model almost_full", DW'(almost_full), DW'(m_af));
        chk("model busy", DW'(busy), DW'(m_busy));
        for (int w = 0; w < NW; w++) begin
            if (m_dv[w]) chk("model deq_data", deq_data[w*DW +: DW], mq[w][0]);
        end
        if (v.chk) begin
            chk("vec enq_ready", DW'(enq_ready), DW'(v.x_rdy));
            chk("vec deq_valid", DW'(deq_valid), DW'(v.x_dv));
            chk("vec count", DW'(count), DW'(v.x_cnt));
            chk("vec almost_full", DW'(almost_full), DW'(v.x_af));
            chk("vec busy", DW'(busy), DW'(v.x_busy));
            if (v.hw >= 0) chk("vec head", deq_data[v.hw*DW +: DW], v.x_head);
        end
        @(posedge clk);
        for (int w = 0; w < NW; w++) begin
            if (v.rst || v.fm[w]) begin
                mq[w].delete();
            end else begin
                if (v.dr[w] && m_dv[w]) void'(mq[w].pop_front());
                if (v.ev && m_rdy && (int'(v.wid) == w)) mq[w].push_back(v.data);
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        // Directed sequences: warp2 fill/drain, warp1 full collision, warp0 wrap,
        // warp3 flush, almost_full threshold, mid-run reset.
        tbl.push_back(tv(1, 2, pl(1), 4'b0000, 4'b0000, 1, 4'b0000, 12'h000, 4'b0000, 0, -1, '0));
        tbl.push_back(tv(1, 2, pl(2), 4'b0000, 4'b0000, 1, 4'b0100, 12'h040, 4'b0000, 1, 2, pl(1)));
        tbl.push_back(tv(1, 2, pl(3), 4'b0000, 4'b0000, 1, 4'b0100, 12'h080, 4'b0000, 1, 2, pl(1)));
        tbl.push_back(tv(1, 2, pl(4), 4'b0000, 4'b0000, 1, 4'b0100, 12'h0C0, 4'b0100, 1, 2, pl(1)));
        tbl.push_back(tv(1, 2, pl(5), 4'b0000, 4'b0000, 0, 4'b0100, 12'h100, 4'b0100, 1, 2, pl(1)));
        tbl.push_back(tv(0, 1, '0,    4'b0000, 4'b0000, 1, 4'b0100, 12'h100, 4'b0100, 1, 2, pl(1)));
        tbl.push_back(tv(0, 2, '0,    4'b0100, 4'b0000, 0, 4'b0100, 12'h100, 4'b0100, 1, 2, pl(1)));
        tbl.push_back(tv(0, 2, '0,    4'b0100, 4'b0000, 1, 4'b0100, 12'h0C0, 4'b0100, 1, 2, pl(2)));
        tbl.push_back(tv(0, 2, '0,    4'b0100, 4'b0000, 1, 4'b0100, 12'h080, 4'b0000, 1, 2, pl(3)));
        tbl.push_back(tv(0, 2, '0,    4'b0100, 4'b0000, 1, 4'b0100, 12'h040, 4'b0000, 1, 2, pl(4)));
        tbl.push_back(tv(0, 2, '0,    4'b0000, 4'b0000, 1, 4'b0000, 12'h000, 4'b0000, 0, -1, '0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 1, pl(10 + i), 4'b0000, 4'b0000));
        tbl.push_back(tv(1, 1, pl(14), 4'b0010, 4'b0000, 0, 4'b0010, 12'h020, 4'b0010, 1, 1, pl(10)));
        tbl.push_back(tv(1, 1, pl(15), 4'b0000, 4'b0000, 1, 4'b0010, 12'h018, 4'b0010, 1, 1, pl(11)));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 1, '0, 4'b0010, 4'b0000));
        for (int i = 0; i < 11; i++) tbl.push_back(mk(0, (i < 10), 0, pl(20 + i), 4'b0001, 4'b0000));
        tbl.push_back(mk(0, 1, 0, pl(40), 4'b0000, 4'b0000));
        tbl.push_back(mk(0, 1, 0, pl(41), 4'b0000, 4'b0000));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 3, pl(42 + i), 4'b0000, 4'b0000));
        tbl.push_back(tv(1, 3, pl(45), 4'b1000, 4'b1000, 0, 4'b0001, 12'h602, 4'b1000, 1, 0, pl(40)));
        tbl.push_back(tv(0, 0, '0,     4'b0000, 4'b0000, 1, 4'b0001, 12'h002, 4'b0000, 1, 0, pl(40)));
        tbl.push_back(tv(1, 0, pl(46), 4'b0000, 4'b0000, 1, 4'b0001, 12'h002, 4'b0000, 1, 0, pl(40)));
        tbl.push_back(tv(0, 0, '0,     4'b0001, 4'b0000, 1, 4'b0001, 12'h003, 4'b0001, 1, 0, pl(40)));
        tbl.push_back(tv(0, 0, '0,     4'b0000, 4'b0000, 1, 4'b0001, 12'h002, 4'b0000, 1, 0, pl(41)));
        tbl.push_back(mk(0, 1, 1, pl(50), 4'b0000, 4'b0000));
        tbl.push_back(mk(1, 1, 2, pl(51), 4'b0111, 4'b0000));
        tbl.push_back(tv(0, 1, '0, 4'b0000, 4'b0000, 1, 4'b0000, 12'h000, 4'b0000, 0, -1, '0));

        reset = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        for (int i = 0; i < 400; i++) begin
            vec_t v;
            logic [NW-1:0] dr;
            logic [NW-1:0] fm;
            for (int w = 0; w < NW; w++) dr[w] = ($urandom_range(0, 2) == 0);
            fm = ($urandom_range(0, 11) == 0) ? NW'($urandom()) : '0;
            v = mk(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                   2'($urandom_range(0, NW - 1)), rnd(), dr, fm);
            apply(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
